dac_load_arbiter: RTL and testbench

Hardware shift engine that loads the comparator-threshold DAC and the pulse-amplitude DAC over their 3-wire serial interfaces. Host software no longer bit-bangs these DACs one register write per edge. Two requesters each present a word and a request. The block grants them round-robin, shifts the word MSB-first on the granted channel's enable/data/clock lines, and returns a one-cycle acknowledge. It sits between the host register bank and the DAC pins, replacing direct register drive of `_cdac_en/cdac_din/cdac_sclk` and `_pdac_en/pdac_din/pdac_sclk`.

---
 rtl/dac_load_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_dac_load_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_load_arbiter.sv
// ----------------------------------------------------------------------------
// dac_load_arbiter
//
// Serial load engine shared by the comparator-threshold DAC (channel 0) and
// the pulse-amplitude DAC (channel 1). Each requester holds a level request
// and a word. The block grants one channel at a time, alternating when both
// ask. It then shifts the granted word MSB-first on that channel's
// enable/data/clock pins and pulses a one-cycle acknowledge when the load
// is done.
//
// Ports
//   clk                          : sole clock, rising edge
//   _reset                       : synchronous, active-low reset
//   req0, data0, ack0            : channel 0 request level, word, done pulse
//   req1, data1, ack1            : channel 1 request level, word, done pulse
//   busy                         : high from the grant until the post-load
//                                  gap ends
//   _cdac_en, cdac_din, cdac_sclk: comparator DAC serial pins
//   _pdac_en, pdac_din, pdac_sclk: pulse DAC serial pins
//
// Every output is a flop. Its next value is computed from the next state,
// so pins change on the same edge as the state they belong to.
// ----------------------------------------------------------------------------
module dac_load_arbiter #(
    parameter int WORD_BITS = 16,
    parameter int CLK_DIV   = 4
) (
    input  logic                 clk,
    input  logic                 _reset,
    input  logic                 req0,
    input  logic [WORD_BITS-1:0] data0,
    output logic                 ack0,
    input  logic                 req1,
    input  logic [WORD_BITS-1:0] data1,
    output logic                 ack1,
    output logic                 busy,
    output logic                 _cdac_en,
    output logic                 cdac_din,
    output logic                 cdac_sclk,
    output logic                 _pdac_en,
    output logic                 pdac_din,
    output logic                 pdac_sclk
);

    localparam int HALF_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W  = $clog2(WORD_BITS + 1);
    localparam logic [HALF_W-1:0] HALF_RELOAD = HALF_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_RELOAD  = BIT_W'(WORD_BITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_HIGH,
        S_LOW,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [HALF_W-1:0]     half_cnt_q, half_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]  shift_q, shift_d;
    logic                  grant_q, grant_d;
    logic                  last_grant_q, last_grant_d;
    logic                  busy_q, busy_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  cdac_en_n_q, cdac_en_n_d;
    logic                  cdac_din_q, cdac_din_d;
    logic                  cdac_sclk_q, cdac_sclk_d;
    logic                  pdac_en_n_q, pdac_en_n_d;
    logic                  pdac_din_q, pdac_din_d;
    logic                  pdac_sclk_q, pdac_sclk_d;

    logic any_req;
    logic grant_sel;
    logic half_done;
    logic grant_fire;
    logic state_entry;
    logic chan_active;
    logic chan_din;
    logic chan_sclk;

    // The last GAP cycle works as an IDLE cycle. A waiting request is
    // granted on the same edge that would otherwise drop busy, so
    // back-to-back loads lose no cycle.
    assign any_req     = req0 | req1;
    assign grant_sel   = (req0 & req1) ? ~last_grant_q : req1;
    assign half_done   = (half_cnt_q == '0);
    assign grant_fire  = any_req &&
                         ((state_q == S_IDLE) || ((state_q == S_GAP) && half_done));
    assign state_entry = (state_d != state_q);

    // State register. Reset returns every pin to idle and drops a partial
    // word without acknowledging it.
    always_ff @(posedge clk) begin
        if (!_reset) begin
            state_q      <= S_IDLE;
            half_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            cdac_en_n_q  <= 1'b1;
            cdac_din_q   <= 1'b0;
            cdac_sclk_q  <= 1'b0;
            pdac_en_n_q  <= 1'b1;
            pdac_din_q   <= 1'b0;
            pdac_sclk_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            half_cnt_q   <= half_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            busy_q       <= busy_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            cdac_en_n_q  <= cdac_en_n_d;
            cdac_din_q   <= cdac_din_d;
            cdac_sclk_q  <= cdac_sclk_d;
            pdac_en_n_q  <= pdac_en_n_d;
            pdac_din_q   <= pdac_din_d;
            pdac_sclk_q  <= pdac_sclk_d;
        end
    end

    // Next state. Each timed phase lasts CLK_DIV cycles. LOW leads to GAP
    // once the bit counter has counted down every bit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (grant_fire) state_d = S_SETUP;
            S_SETUP: if (half_done)  state_d = S_HIGH;
            S_HIGH:  if (half_done)  state_d = S_LOW;
            S_LOW:   if (half_done)  state_d = (bit_cnt_q == '0) ? S_GAP : S_HIGH;
            S_GAP:   if (half_done)  state_d = grant_fire ? S_SETUP : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and pin values for the cycle after this edge. Shifting at LOW
    // entry fills in zeros. After the final bit, din therefore reads 0
    // through the enable hold phase with no special case.
    always_comb begin
        half_cnt_d   = half_done ? half_cnt_q : half_cnt_q - HALF_W'(1);
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        if (state_entry) begin
            half_cnt_d = HALF_RELOAD;
        end

        if (grant_fire) begin
            shift_d      = grant_sel ? data1 : data0;
            grant_d      = grant_sel;
            last_grant_d = grant_sel;
            bit_cnt_d    = BIT_RELOAD;
        end else if (state_entry && (state_d == S_LOW)) begin
            shift_d   = {shift_q[WORD_BITS-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
        end

        if (state_entry && (state_d == S_GAP)) begin
            ack0_d = ~grant_q;
            ack1_d = grant_q;
        end

        busy_d = (state_d != S_IDLE);

        chan_active = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
        chan_din    = chan_active & shift_d[WORD_BITS-1];
        chan_sclk   = (state_d == S_HIGH);

        // Only the granted channel's pins move; the other channel stays idle.
        cdac_en_n_d = 1'b1;
        cdac_din_d  = 1'b0;
        cdac_sclk_d = 1'b0;
        pdac_en_n_d = 1'b1;
        pdac_din_d  = 1'b0;
        pdac_sclk_d = 1'b0;
        if (grant_d) begin
            pdac_en_n_d = ~chan_active;
            pdac_din_d  = chan_din;
            pdac_sclk_d = chan_sclk;
        end else begin
            cdac_en_n_d = ~chan_active;
            cdac_din_d  = chan_din;
            cdac_sclk_d = chan_sclk;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign busy      = busy_q;
    assign _cdac_en  = cdac_en_n_q;
    assign cdac_din  = cdac_din_q;
    assign cdac_sclk = cdac_sclk_q;
    assign _pdac_en  = pdac_en_n_q;
    assign pdac_din  = pdac_din_q;
    assign pdac_sclk = pdac_sclk_q;

endmodule

// File: tb/tb_dac_load_arbiter.sv
// ----------------------------------------------------------------------------
// tb_dac_load_arbiter
//
// Drives two arbiter instances. Instance A uses the default word length and
// divider. Instance B uses the smallest divider and word length. A timeline
// reference model predicts every output of both instances on every cycle.
// The model records only who holds the grant, which word was latched and how
// many cycles have passed since the grant. The pin values come from the
// timing equations for a load. Directed scenarios add pointed checks on top
// of that, and then a randomized requester phase follows.
// ----------------------------------------------------------------------------
module tb_dac_load_arbiter;

    typedef struct {
        logic        active;
        logic        chan;
        logic [31:0] word;
        int          t;
        logic        last;
    } mdlT;

    logic clk;
    logic rstN;

    logic        req0A, req1A, ack0A, ack1A, busyA;
    logic [15:0] data0A, data1A;
    logic        cEnA, cDinA, cSclkA, pEnA, pDinA, pSclkA;

    logic        req0B, req1B, ack0B, ack1B, busyB;
    logic [1:0]  data0B, data1B;
    logic        cEnB, cDinB, cSclkB, pEnB, pDinB, pSclkB;

    logic [8:0]  obsA, obsB;
    mdlT         mA, mB;
    logic        armed;

    int checks;
    int failures;

    dac_load_arbiter #(.WORD_BITS(16), .CLK_DIV(4)) dutA (
        .clk(clk), ._reset(rstN),
        .req0(req0A), .data0(data0A), .ack0(ack0A),
        .req1(req1A), .data1(data1A), .ack1(ack1A),
        .busy(busyA),
        ._cdac_en(cEnA), .cdac_din(cDinA), .cdac_sclk(cSclkA),
        ._pdac_en(pEnA), .pdac_din(pDinA), .pdac_sclk(pSclkA)
    );

    dac_load_arbiter #(.WORD_BITS(2), .CLK_DIV(1)) dutB (
        .clk(clk), ._reset(rstN),
        .req0(req0B), .data0(data0B), .ack0(ack0B),
        .req1(req1B), .data1(data1B), .ack1(ack1B),
        .busy(busyB),
        ._cdac_en(cEnB), .cdac_din(cDinB), .cdac_sclk(cSclkB),
        ._pdac_en(pEnB), .pdac_din(pDinB), .pdac_sclk(pSclkB)
    );

    assign obsA = {busyA, ack0A, ack1A, cEnA, cDinA, cSclkA, pEnA, pDinA, pSclkA};
    assign obsB = {busyB, ack0B, ack1B, cEnB, cDinB, cSclkB, pEnB, pDinB, pSclkB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The one place where observed and expected values meet.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // One clock edge of a load. A load runs D*(2+2W) cycles after its grant.
    // The edge that ends it may grant the next request straight away.
    function automatic mdlT stepModel(mdlT m, logic rst, logic r0, logic r1,
                                      logic [31:0] d0, logic [31:0] d1, int D, int W);
        mdlT  n;
        logic canGrant;
        n = m;
        if (!rst) begin
            n.active = 1'b0;
            n.chan   = 1'b0;
            n.t      = 0;
            n.last   = 1'b1;
            return n;
        end
        canGrant = !m.active;
        if (m.active) begin
            n.t = m.t + 1;
            if (n.t == D * (2 + 2 * W)) begin
                n.active = 1'b0;
                canGrant = 1'b1;
            end
        end
        if (canGrant && (r0 || r1)) begin
            n.chan   = (r0 && r1) ? ~m.last : r1;
            n.word   = n.chan ? d1 : d0;
            n.last   = n.chan;
            n.active = 1'b1;
            n.t      = 0;
        end
        return n;
    endfunction

    // Expected outputs t cycles after a grant. Enable is low for the first
    // D*(1+2W) cycles. Bit k is on din during [2kD, 2kD+2D), and sclk is
    // high in the second half of that window. The acknowledge comes on the
    // cycle the enable rises.
    function automatic logic [8:0] expOut(mdlT m, int D, int W);
        logic en, din, sclk, ack;
        logic [2:0] act, idle;
        int k;
        en   = 1'b0;
        din  = 1'b0;
        sclk = 1'b0;
        ack  = 1'b0;
        idle = 3'b100;
        if (m.active) begin
            if (m.t < D * (1 + 2 * W)) begin
                en   = 1'b1;
                k    = m.t / (2 * D);
                din  = (k < W) ? m.word[W - 1 - k] : 1'b0;
                sclk = ((m.t % (2 * D)) >= D);
            end
            ack = (m.t == D * (1 + 2 * W));
        end
        act = {~en, din, sclk};
        if (m.chan)
            return {m.active, 1'b0, ack, idle, act};
        else
            return {m.active, ack, 1'b0, act, idle};
    endfunction

    always @(posedge clk) begin
        mA <= stepModel(mA, rstN, req0A, req1A, 32'(data0A), 32'(data1A), 4, 16);
        mB <= stepModel(mB, rstN, req0B, req1B, 32'(data0B), 32'(data1B), 1, 2);
        if (!rstN) armed <= 1'b1;
    end

    always @(negedge clk) begin
        if (armed) begin
            checkOutput("modelA", 32'(obsA), 32'(expOut(mA, 4, 16)));
            checkOutput("modelB", 32'(obsB), 32'(expOut(mB, 1, 2)));
        end
    end

    // A requester raises its request with a fresh word, holds it until it
    // sees its acknowledge, and sometimes gives up early. The word churns
    // at random times.
    task automatic randReq(input logic ackSeen, input logic reqIn, input logic [31:0] dataIn,
                           output logic reqOut, output logic [31:0] dataOut);
        reqOut  = reqIn;
        dataOut = dataIn;
        if (reqIn && ackSeen)
            reqOut = 1'b0;
        else if (!reqIn && ($urandom_range(0, 7) == 0)) begin
            reqOut  = 1'b1;
            dataOut = $urandom;
        end else if (reqIn && ($urandom_range(0, 299) == 0))
            reqOut = 1'b0;
        if ($urandom_range(0, 15) == 0) dataOut = $urandom;
    endtask

    task automatic applyStimulus();
        logic        r;
        logic [31:0] d;
        @(negedge clk);
        rstN = ($urandom_range(0, 2999) != 0);
        randReq(ack0A, req0A, 32'(data0A), r, d); req0A = r; data0A = d[15:0];
        randReq(ack1A, req1A, 32'(data1A), r, d); req1A = r; data1A = d[15:0];
        randReq(ack0B, req0B, 32'(data0B), r, d); req0B = r; data0B = d[1:0];
        randReq(ack1B, req1B, 32'(data1B), r, d); req1B = r; data1B = d[1:0];
    endtask

    initial begin
        logic [15:0] loadWord;
        logic [15:0] got;
        bit          ackOrder[$];

        checks   = 0;
        failures = 0;
        armed    = 1'b0;
        rstN     = 1'b0;
        {req0A, req1A, req0B, req1B} = 4'b0000;
        data0A = '0; data1A = '0; data0B = '0; data1B = '0;
        $display("[TB] start");

        // Idle pins after reset.
        repeat (3) @(negedge clk);
        checkOutput("resetA", 32'(obsA), 32'(9'b000_100_100));
        checkOutput("resetB", 32'(obsB), 32'(9'b000_100_100));
        rstN = 1'b1;
        @(negedge clk);

        // A single load of 0xA5C3 on channel 0.
        loadWord = 16'hA5C3;
        req0A    = 1'b1;
        data0A   = loadWord;
        for (int t = 0; t <= 137; t++) begin
            @(negedge clk);
            if ((t % 8 == 4) && (t < 128))
                checkOutput("bitRise", 32'({cSclkA, cDinA}), 32'({1'b1, loadWord[15 - (t - 4) / 8]}));
            checkOutput("pdacIdle", 32'({pEnA, pDinA, pSclkA}), 32'(3'b100));
            if (t >= 131 && t <= 133) checkOutput("ack0At132", 32'(ack0A), 32'(t == 132));
            if (t == 135 || t == 136) checkOutput("busyFall136", 32'(busyA), 32'(t == 135));
            if (t == 132) req0A = 1'b0;
        end

        // Both requests right after reset, held over four loads.
        rstN = 1'b0;
        @(negedge clk);
        rstN  = 1'b1;
        req0A = 1'b1;
        req1A = 1'b1;
        for (int t = 0; t <= 545; t++) begin
            @(negedge clk);
            checkOutput("ackExclusive", 32'(ack0A & ack1A), 32'(0));
            if (ack0A || ack1A) ackOrder.push_back(ack1A);
            if (t == 0)   checkOutput("firstGrantCh0", 32'({cEnA, pEnA}), 32'(2'b01));
            if (t == 136) checkOutput("grantCh1At136", 32'({cEnA, pEnA}), 32'(2'b10));
            if (t == 268) checkOutput("ack1At268", 32'(ack1A), 32'(1));
            if (t == 540) begin
                req0A = 1'b0;
                req1A = 1'b0;
            end
        end
        checkOutput("ackCount", 32'(ackOrder.size()), 32'(4));
        foreach (ackOrder[i]) checkOutput("ackOrder", 32'(ackOrder[i]), 32'(i % 2));

        // The word is latched at the grant, so a later change is ignored.
        got    = '0;
        req1A  = 1'b1;
        data1A = 16'h1234;
        for (int t = 0; t <= 137; t++) begin
            @(negedge clk);
            if (t == 10) data1A = 16'hFFFF;
            if ((t % 8 == 4) && (t < 128)) got = {got[14:0], pDinA};
            if (t == 132) req1A = 1'b0;
        end
        checkOutput("dataLatched", 32'(got), 32'(16'h1234));

        // Reset at cycle 50 of a channel 0 load.
        req0A  = 1'b1;
        data0A = 16'hBEEF;
        for (int t = 0; t < 50; t++) @(negedge clk);
        rstN  = 1'b0;
        req0A = 1'b0;
        @(negedge clk);
        checkOutput("resetMidShift", 32'({cEnA, cSclkA, busyA}), 32'(3'b100));
        rstN = 1'b1;
        for (int t = 0; t < 140; t++) begin
            @(negedge clk);
            checkOutput("noAckAfterReset", 32'(ack0A), 32'(0));
        end
        req0A = 1'b1;
        req1A = 1'b1;
        @(negedge clk);
        checkOutput("postResetGrantCh0", 32'({cEnA, pEnA}), 32'(2'b01));
        req0A = 1'b0;
        req1A = 1'b0;
        repeat (140) @(negedge clk);

        // Smallest divider and word length on instance B.
        req0B  = 1'b1;
        data0B = 2'b10;
        for (int t = 0; t <= 7; t++) begin
            @(negedge clk);
            if (t == 1) checkOutput("minRise1", 32'({cSclkB, cDinB}), 32'(2'b11));
            if (t == 2) checkOutput("minLow1", 32'(cSclkB), 32'(0));
            if (t == 3) checkOutput("minRise2", 32'({cSclkB, cDinB}), 32'(2'b10));
            if (t == 4 || t == 5) checkOutput("minAck5", 32'(ack0B), 32'(t == 5));
            if (t == 5 || t == 6) checkOutput("minBusy6", 32'(busyB), 32'(t == 5));
            if (t == 5) req0B = 1'b0;
        end

        // Randomized requesters on both instances.
        repeat (12000) applyStimulus();
        @(negedge clk);
        rstN = 1'b1;
        {req0A, req1A, req0B, req1B} = 4'b0000;
        repeat (300) @(negedge clk);
        checkOutput("drainIdleA", 32'(busyA), 32'(0));
        checkOutput("drainIdleB", 32'(busyB), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
